// File: rtl/hamming_encoder_stream.sv
// rtl/hamming_encoder_stream.sv - Hamming encoder with burst FSM and output FIFO
// Define HAMMING_SECDED_EN to append an overall even-parity bit (SECDED).
module hamming_encoder_stream #(
  parameter int DATA_W     = 4,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int PAR_W = (DATA_W <= 1)  ? 2 :
                         (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W
`ifdef HAMMING_SECDED_EN
                          + 1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [7:0] LAST_WORD = 8'(BURST_LEN - 1);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t state, state_nxt;
  logic [7:0] word_cnt;
  logic cnt_clr;

  // Data bit i sits at the i-th non-power-of-two Hamming position (3,5,6,7,9,...).
  function automatic logic [DATA_W-1:0] par_mask(input int j);
    logic [DATA_W-1:0] m;
    int idx;
    m = '0;
    idx = 0;
    for (int p = 3; p < 64; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (idx < DATA_W && ((p >> j) & 1) == 1) m = m | (DATA_W'(1) << idx);
        idx++;
      end
    end
    return m;
  endfunction

  logic [PAR_W-1:0]  enc_par;
  logic [CODE_W-1:0] enc_code;

  for (genvar j = 0; j < PAR_W; j++) begin : g_par
    assign enc_par[j] = ^(in_data & par_mask(j));
  end

`ifdef HAMMING_SECDED_EN
  assign enc_code = {^{enc_par, in_data}, enc_par, in_data};
`else
  assign enc_code = {enc_par, in_data};
`endif

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    occ;
  logic [CODE_W-1:0] last_code;
  logic fifo_full, fifo_empty, push, pop;

  assign fifo_full  = (occ == FULL_OCC);
  assign fifo_empty = (occ == '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_valid  = !fifo_empty;
  // When empty the head slot may be stale or unwritten, so present the last popped code.
  assign out_code   = fifo_empty ? last_code : mem[rd_ptr];
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      last_code <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_code <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (cnt_clr) word_cnt <= '0;
      else if (push) word_cnt <= word_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
          cnt_clr   = 1'b1;
        end
      end
      ST_RUN: begin
        in_ready = !fifo_full;
        if (push && word_cnt == LAST_WORD) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb/tb_hamming_encoder_stream.sv - directed and random checks of hamming_encoder_stream
module tb_hamming_encoder_stream;

`ifdef HAMMING_SECDED_EN
  localparam int CA = 8;
  localparam int CB = 16;
`else
  localparam int CA = 7;
  localparam int CB = 15;
`endif
  localparam int POS_B [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy, a_done;
  logic [3:0]    a_in_data;
  logic [CA-1:0] a_out_code;
  logic b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy, b_done;
  logic [10:0]   b_in_data;
  logic [CB-1:0] b_out_code;

  hamming_encoder_stream #(.DATA_W(4), .BURST_LEN(4), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_code(a_out_code), .busy(a_busy), .done(a_done)
  );

  hamming_encoder_stream #(.DATA_W(11), .BURST_LEN(8), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .busy(b_busy), .done(b_done)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [CA-1:0] a_got [$];
  logic [CB-1:0] b_got [$];
  int a_done_cnt = 0, a_done_cyc = 0, a_last_pop = 0, b_done_cnt = 0;

  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_got.push_back(a_out_code);
      a_last_pop = cyc;
    end
    if (a_done) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    if (b_out_valid && b_out_ready) b_got.push_back(b_out_code);
    if (b_done) b_done_cnt++;
  end

  function automatic logic [CB-1:0] ref_b(input logic [10:0] d);
    logic [3:0] par;
    logic [10:0] t;
    par = '0;
    for (int i = 0; i < 11; i++) begin
      t = d >> i;
      if (t[0]) par = par ^ 4'(POS_B[i]);
    end
`ifdef HAMMING_SECDED_EN
    return {^{par, d}, par, d};
`else
    return {par, d};
`endif
  endfunction

  function automatic int synd_b(input logic [CB-1:0] c);
    int s;
    logic [CB-1:0] t;
    s = 0;
    for (int i = 0; i < 15; i++) begin
      t = c >> i;
      if (t[0]) s = s ^ ((i < 11) ? POS_B[i] : (1 << (i - 11)));
    end
`ifdef HAMMING_SECDED_EN
    if (^c) s = s | 32'h100;
`endif
    return s;
  endfunction

  task automatic start_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic start_b();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic send_a(input logic [3:0] d);
    int n;
    n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    @(negedge clk);
    while (!a_in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!a_in_ready) check("send_a_timeout", 0, 1);
    @(posedge clk); #1 a_in_valid = 1'b0;
  endtask

  logic [10:0] b_words [$];
  int b_acc;

  task automatic b_feed_until(input int target, input bit rnd_ready);
    int n;
    bit acc;
    n = 0;
    while (b_acc < target && n < 500) begin
      b_in_valid = 1'b1;
      b_in_data  = b_words[b_acc];
      if (rnd_ready) b_out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk); #1;
      if (acc) b_acc++;
      n++;
    end
    b_in_valid = 1'b0;
    if (b_acc < target) check("b_feed_timeout", 64'(b_acc), 64'(target));
  endtask

  task automatic wait_done_a(input int t);
    int n;
    n = 0;
    while (a_done_cnt < t && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_done_a", 64'(a_done_cnt >= t), 1);
  endtask

  task automatic wait_done_b(input int t);
    int n;
    n = 0;
    while (b_done_cnt < t && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("wait_done_b", 64'(b_done_cnt >= t), 1);
  endtask

  logic [CA-1:0] exp1 [4];
  logic [CA-1:0] exp4 [4];
  logic [CA-1:0] exp5 [4];
  logic [CB-1:0] k7ff;

  initial begin
`ifdef HAMMING_SECDED_EN
    exp1 = '{8'h1B, 8'hFF, 8'h00, 8'hB1};
    exp4 = '{8'hB1, 8'h00, 8'hFF, 8'h1B};
    exp5 = '{8'hD2, 8'h00, 8'h1B, 8'hFF};
    k7ff = 16'hFFFF;
`else
    exp1 = '{7'h1B, 7'h7F, 7'h00, 7'h31};
    exp4 = '{7'h31, 7'h00, 7'h7F, 7'h1B};
    exp5 = '{7'h52, 7'h00, 7'h1B, 7'h7F};
    k7ff = 15'h7FFF;
`endif
    reset = 1'b0;
    a_start = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_start = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 0);
    check("rst_out_valid", 64'(a_out_valid), 0);
    check("rst_out_code", 64'(a_out_code), 0);
    check("rst_busy", 64'(a_busy), 0);
    check("rst_done", 64'(a_done), 0);
    check("rst_b_out_valid", 64'(b_out_valid), 0);
    @(posedge clk); #1 reset = 1'b1;

    // data offered in IDLE without start is ignored
    a_in_valid = 1'b1; a_in_data = 4'h5;
    repeat (3) begin
      @(negedge clk);
      check("idle_in_ready", 64'(a_in_ready), 0);
      check("idle_out_valid", 64'(a_out_valid), 0);
    end
    @(posedge clk); #1 a_in_valid = 1'b0;

    // basic burst
    a_out_ready = 1'b1;
    a_got.delete();
    start_a();
    send_a(4'hB); send_a(4'hF); send_a(4'h0); send_a(4'h1);
    wait_done_a(1);
    check("t1_count", 64'(a_got.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_code%0d", i), 64'(a_got[i]), 64'(exp1[i]));
    check("t1_done_lat", 64'(a_done_cyc - a_last_pop), 1);
    @(negedge clk);
    check("t1_busy_after", 64'(a_busy), 0);
    check("t1_done_once", 64'(a_done_cnt), 1);

    // start during RUN must not restart the burst
    a_got.delete();
    start_a();
    send_a(4'h1); send_a(4'h0);
    start_a();
    send_a(4'hF); send_a(4'hB);
    @(negedge clk);
    check("t4_in_ready_after", 64'(a_in_ready), 0);
    check("t4_busy", 64'(a_busy), 1);
    wait_done_a(2);
    check("t4_count", 64'(a_got.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t4_code%0d", i), 64'(a_got[i]), 64'(exp4[i]));
    a_in_valid = 1'b1; a_in_data = 4'h7;
    repeat (3) @(negedge clk);
    check("t4_idle_out_valid", 64'(a_out_valid), 0);
    a_in_valid = 1'b0;
    check("t4_idle_no_accept", 64'(a_got.size()), 4);

    // reset in the middle of a burst
    a_got.delete();
    a_out_ready = 1'b0;
    start_a();
    send_a(4'h3); send_a(4'h6);
    #2 reset = 1'b0;
    #1;
    check("t5_in_ready", 64'(a_in_ready), 0);
    check("t5_out_valid", 64'(a_out_valid), 0);
    check("t5_out_code", 64'(a_out_code), 0);
    check("t5_busy", 64'(a_busy), 0);
    check("t5_done", 64'(a_done), 0);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_done", 64'(a_done_cnt), 2);
    a_out_ready = 1'b1;
    start_a();
    send_a(4'h2); send_a(4'h0); send_a(4'hB); send_a(4'hF);
    wait_done_a(3);
    check("t5_count", 64'(a_got.size()), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t5_code%0d", i), 64'(a_got[i]), 64'(exp5[i]));

    // backpressure: FIFO fills at 4, then releases
    b_words = '{11'h7FF, 11'h001, 11'h002, 11'h400, 11'h123, 11'h555, 11'h2AA, 11'h0F0};
    b_acc = 0;
    b_got.delete();
    b_out_ready = 1'b0;
    start_b();
    b_feed_until(4, 1'b0);
    b_in_valid = 1'b1; b_in_data = b_words[4];
    repeat (5) begin
      @(negedge clk);
      check("t3_in_ready_full", 64'(b_in_ready), 0);
      check("t3_head_stable", 64'(b_out_code), 64'(k7ff));
    end
    check("t3_out_valid", 64'(b_out_valid), 1);
    check("t3_accepted", 64'(b_acc), 4);
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    b_feed_until(8, 1'b0);
    wait_done_b(1);
    check("t3_count", 64'(b_got.size()), 8);
    check("t6_7ff", 64'(b_got[0]), 64'(k7ff));
    for (int i = 1; i < 8; i++) check($sformatf("t3_code%0d", i), 64'(b_got[i]), 64'(ref_b(b_words[i])));

    // random words with random backpressure
    b_words.delete();
    for (int i = 0; i < 8; i++) b_words.push_back(11'($urandom_range(0, 2047)));
    b_acc = 0;
    b_got.delete();
    start_b();
    b_feed_until(8, 1'b1);
    b_out_ready = 1'b1;
    wait_done_b(2);
    check("t6_count", 64'(b_got.size()), 8);
    for (int i = 0; i < 8 && i < b_got.size(); i++) begin
      check($sformatf("t6_code%0d", i), 64'(b_got[i]), 64'(ref_b(b_words[i])));
      check($sformatf("t6_synd%0d", i), 64'(synd_b(b_got[i])), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
